// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle RISC-V controller: state codes, opcodes,
// ALUOp classes, alu_control codes and datapath mux select encodings.
package multicycle_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_JAL      = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, selects and strobes out.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, state, instr_done, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, state, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode: ALUOp class plus funct fields -> alu_control.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type uses funct7b5; addi with imm[10]=1 must stay add
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multicycle RISC-V datapath. Optional single-step mode:
// the FSM and every write strobe are gated by en so a board key walks one state per press.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit SINGLE_STEP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    multicycle_ctrl_if.master bus
);

    logic [3:0] state_q, state_d, state_eff;
    logic       en_eff, gate;
    logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic       done_raw, illegal_raw, pc_from_zero;
    logic [1:0] aluop;

    assign en_eff = SINGLE_STEP ? en : 1'b1;
    assign gate   = en_eff & rst;

    always_comb begin
        state_d = state_q;
        if (!rst) begin
            state_d = S_FETCH;
        end else if (en_eff) begin
            case (state_q)
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECUTER;
                        OP_I:         state_d = S_EXECUTEI;
                        OP_JAL:       state_d = S_JAL;
                        OP_BEQ:       state_d = S_BEQ;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_d = S_MEMWB;
                S_EXECUTER: state_d = S_ALUWB;
                S_EXECUTEI: state_d = S_ALUWB;
                S_JAL:      state_d = S_ALUWB;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // While reset is asserted the selects already look like FETCH.
    assign state_eff = rst ? state_q : S_FETCH;

    always_comb begin
        pc_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        done_raw       = 1'b0;
        illegal_raw    = 1'b0;
        pc_from_zero   = 1'b0;
        aluop          = ALUOP_ADD;
        bus.adr_src    = 1'b0;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RD2;
        case (state_eff)
            S_FETCH: begin
                ir_write_raw   = 1'b1;
                pc_write_raw   = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                illegal_raw   = !is_legal_op(bus.op);
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RD1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                reg_write_raw  = 1'b1;
                done_raw       = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_EXECUTER: begin
                bus.alu_src_a = SRCA_RD1;
                aluop         = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                bus.alu_src_a = SRCA_RD1;
                bus.alu_src_b = SRCB_IMM;
                aluop         = ALUOP_FUNCT;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_write_raw  = 1'b1;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a = SRCA_RD1;
                aluop         = ALUOP_SUB;
                pc_from_zero  = 1'b1;
                done_raw      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_write   = (pc_write_raw | (pc_from_zero & bus.zero)) & gate;
    assign bus.mem_write  = mem_write_raw & gate;
    assign bus.ir_write   = ir_write_raw & gate;
    assign bus.reg_write  = reg_write_raw & gate;
    assign bus.instr_done = done_raw & gate;
    assign bus.illegal    = illegal_raw & gate;
    assign bus.state      = state_q;

    always_comb begin
        case (bus.op)
            OP_SW:   bus.imm_src = IMM_S;
            OP_BEQ:  bus.imm_src = IMM_B;
            OP_JAL:  bus.imm_src = IMM_J;
            default: bus.imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (bus.alu_control)
    );

endmodule
